// File: rtl/key_press_detector.sv
// Debounced push-button event generator: level, press pulse and release pulse.
// Optional auto-repeat of the press pulse while held is enabled by defining AUTO_REPEAT_EN.
module key_press_detector #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic keyN,
    output logic keyIsPressed,
    output logic keyPressPulse,
    output logic keyReleasePulse
);

    localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DEB_MAX    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam bit                ONE_SAMPLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             sync1_r;
    logic             sync2_r;
    logic             key_s;
    logic             press_s;
    logic             release_s;
    logic             repeat_s;

    assign key_s = sync2_r;

    // Two-flop synchronizer on the inverted (active-high) pin
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= ~keyN;
            sync2_r <= sync1_r;
        end
    end

    // Debounce FSM next state; the current sample counts toward DEBOUNCE_CYCLES
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cnt_inc_s   = (cnt_r >= DEB_MAX) ? DEB_MAX : (cnt_r + CNT_ONE);
        case (state_r)
            IDLE: begin
                if (key_s) begin
                    if (ONE_SAMPLE) begin
                        state_nxt_s = HELD;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = PRESS_WAIT;
                        cnt_nxt_s   = CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = CNT_ZERO;
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_inc_s == DEB_MAX) begin
                    state_nxt_s = HELD;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            HELD: begin
                if (!key_s) begin
                    if (ONE_SAMPLE) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = RELEASE_WAIT;
                        cnt_nxt_s   = CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = CNT_ZERO;
                end
            end
            RELEASE_WAIT: begin
                if (key_s) begin
                    state_nxt_s = HELD;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_inc_s == DEB_MAX) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int               REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               REP_W    = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DLY  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PER  = REP_W'(REPEAT_PERIOD);
    localparam logic [REP_W-1:0] REP_ZERO = REP_W'(0);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    logic [REP_W-1:0] rep_cnt_r;
    logic [REP_W-1:0] rep_cnt_nxt_s;
    logic [REP_W-1:0] rep_limit_s;
    logic             rep_first_r;
    logic             rep_first_nxt_s;

    // Repeat counter counts HELD cycles since entry or the last repeat pulse
    always_comb begin
        rep_cnt_nxt_s   = rep_cnt_r;
        rep_first_nxt_s = rep_first_r;
        repeat_s        = 1'b0;
        rep_limit_s     = rep_first_r ? REP_DLY : REP_PER;
        if ((state_nxt_s == HELD) && (state_r != HELD) && (state_r != RELEASE_WAIT)) begin
            rep_cnt_nxt_s   = REP_ZERO;
            rep_first_nxt_s = 1'b1;
        end else if (state_nxt_s == HELD) begin
            if (rep_cnt_r >= (rep_limit_s - REP_ONE)) begin
                repeat_s        = 1'b1;
                rep_cnt_nxt_s   = REP_ZERO;
                rep_first_nxt_s = 1'b0;
            end else begin
                rep_cnt_nxt_s = rep_cnt_r + REP_ONE;
            end
        end else begin
            rep_cnt_nxt_s = rep_cnt_r;
        end
    end

    // Repeat counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_r   <= REP_ZERO;
            rep_first_r <= 1'b0;
        end else begin
            rep_cnt_r   <= rep_cnt_nxt_s;
            rep_first_r <= rep_first_nxt_s;
        end
    end
`else
    assign repeat_s = 1'b0;
`endif

    // Event decode from the transition being taken this cycle
    always_comb begin
        press_s   = (((state_r == PRESS_WAIT) || (state_r == IDLE)) && (state_nxt_s == HELD)) || repeat_s;
        release_s = ((state_r == RELEASE_WAIT) || (state_r == HELD)) && (state_nxt_s == IDLE);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            cnt_r           <= CNT_ZERO;
            keyIsPressed    <= 1'b0;
            keyPressPulse   <= 1'b0;
            keyReleasePulse <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            cnt_r           <= cnt_nxt_s;
            keyIsPressed    <= (state_nxt_s == HELD) || (state_nxt_s == RELEASE_WAIT);
            keyPressPulse   <= press_s;
            keyReleasePulse <= release_s;
        end
    end

endmodule

// File: tb/tb_key_press_detector.sv
// Directed self-checking bench for key_press_detector (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Expectations follow AUTO_REPEAT_EN when it is defined for the build.
module tb_key_press_detector;

    logic clk;
    logic reset;
    logic keyN;
    logic keyIsPressed;
    logic keyPressPulse;
    logic keyReleasePulse;

    int n_checks;
    int n_errors;

`ifdef AUTO_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    key_press_detector #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .keyN           (keyN),
        .keyIsPressed   (keyIsPressed),
        .keyPressPulse  (keyPressPulse),
        .keyReleasePulse(keyReleasePulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int r, input logic lvl, input logic prs, input logic rel);
        check($sformatf("%s_level_c%0d", tag, r), keyIsPressed, lvl);
        check($sformatf("%s_press_c%0d", tag, r), keyPressPulse, prs);
        check($sformatf("%s_release_c%0d", tag, r), keyReleasePulse, rel);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        keyN     = 1'b0;

        // reset held 3 cycles with the key pressed
        for (int r = 1; r <= 3; r++) begin
            step();
            check_all("reset", r, 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b0;
        step();
        check_all("post_reset", 0, 1'b0, 1'b0, 1'b0);
        keyN = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            step();
            check_all("settle", r, 1'b0, 1'b0, 1'b0);
        end

        // clean press: accepted 6 cycles after the pin edge
        keyN = 1'b0;
        for (int r = 1; r <= 8; r++) begin
            step();
            check_all("press", r, (r >= 6), (r == 6), 1'b0);
        end

        // release glitch of 2 cycles while held is rejected
        keyN = 1'b1;
        for (int r = 1; r <= 6; r++) begin
            step();
            if (r == 2) keyN = 1'b0;
            check_all("glitch", r, 1'b1, 1'b0, 1'b0);
        end

        // clean release: pulse 6 cycles after the pin edge
        keyN = 1'b1;
        for (int r = 1; r <= 9; r++) begin
            step();
            check_all("release", r, (r < 6), 1'b0, (r == 6));
        end

        // press bounce: pin low 3 cycles only
        keyN = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            step();
            if (r == 3) keyN = 1'b1;
            check_all("bounce", r, 1'b0, 1'b0, 1'b0);
        end

        // long hold: HELD entry at cycle 6, repeats at held cycles 10,13,16,19
        keyN = 1'b0;
        for (int r = 1; r <= 26; r++) begin
            step();
            check_all("hold", r, (r >= 6),
                      (r == 6) || (REP_ON && ((r == 16) || (r == 19) || (r == 22) || (r == 25))),
                      1'b0);
        end

        // reset while held: outputs clear, no release pulse
        reset = 1'b1;
        step();
        check_all("reset_held", 1, 1'b0, 1'b0, 1'b0);
        keyN = 1'b1;
        step();
        check_all("reset_held", 2, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int r = 3; r <= 10; r++) begin
            step();
            check_all("reset_held", r, 1'b0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
